// File: rtl/alu_pkg.sv
// Shared types for the Argon ALU/MDU: op and bus-command encodings, flag layout,
// and the iterative engine's state encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADC  = 4'h1,
        OP_SBC  = 4'h2,
        OP_INC  = 4'h3,
        OP_DEC  = 4'h4,
        OP_NAND = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_NOR  = 4'h8,
        OP_XOR  = 4'h9,
        OP_LSH  = 4'hA,
        OP_RSH  = 4'hB,
        OP_MUL  = 4'hC,
        OP_DIV  = 4'hD
    } alu_op_t;

    typedef enum logic [3:0] {
        CMD_NOP      = 4'h0,
        CMD_LATCH_A  = 4'h1,
        CMD_LATCH_B  = 4'h2,
        CMD_LATCH_F  = 4'h3,
        CMD_LATCH_OP = 4'h4,
        CMD_OUT_Y    = 4'h5,
        CMD_OUT_F    = 4'h6,
        CMD_OUT_H    = 4'h7,
        CMD_SAVE_F   = 4'h8
    } alu_cmd_t;

    localparam int F_CARRY   = 0;
    localparam int F_ZERO    = 1;
    localparam int F_EQUAL   = 2;
    localparam int F_GREATER = 3;
    localparam int F_LESS    = 4;
    localparam int F_BORROW  = 5;
    localparam int F_DIVZ    = 6;
    localparam int FLAG_BITS = 7;

    // Declared MSB first so that carry lands on bit 0 of the packed word.
    typedef struct packed {
        logic divz;
        logic borrow;
        logic less;
        logic greater;
        logic equal;
        logic zero;
        logic carry;
    } alu_flags_t;

    typedef enum logic {
        ITER_IDLE = 1'b0,
        ITER_RUN  = 1'b1
    } iter_state_t;

endpackage

// File: rtl/argon_alu_iter.sv
// One-bit-per-cycle shift-add multiplier and restoring divider sharing a hi/lo pair.
// The divider exists only when ARGON_ALU_DIV_EN is defined.
module argon_alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o,
    output iter_state_t      state_o
);
    localparam int CW = $clog2(WIDTH);

    iter_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
`ifdef ARGON_ALU_DIV_EN
    logic             div_q, div_d;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
`else
    logic             unused_op;
    assign unused_op = ^op_i;
`endif

    // lo holds the multiplier (MUL) or the dividend being shifted out (DIV).
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        nxt_hi  = mul_sum[WIDTH:1];
        nxt_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef ARGON_ALU_DIV_EN
        div_rem  = {hi_q, lo_q[WIDTH-1]};
        div_ge   = (div_rem >= {1'b0, b_q});
        // The difference is always below the divisor, so the low WIDTH bits suffice.
        div_diff = div_rem[WIDTH-1:0] - b_q;
        if (div_q) begin
            nxt_hi = div_ge ? div_diff : div_rem[WIDTH-1:0];
            nxt_lo = {lo_q[WIDTH-2:0], div_ge};
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        done_o  = 1'b0;
`ifdef ARGON_ALU_DIV_EN
        div_d   = div_q;
`endif
        case (state_q)
            ITER_IDLE: begin
                if (start_i) begin
                    state_d = ITER_RUN;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = a_i;
                    b_d     = b_i;
`ifdef ARGON_ALU_DIV_EN
                    div_d   = (op_i == OP_DIV);
`endif
                end
            end
            ITER_RUN: begin
                hi_d  = nxt_hi;
                lo_d  = nxt_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    done_o  = 1'b1;
                    state_d = ITER_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ITER_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ITER_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
`ifdef ARGON_ALU_DIV_EN
            div_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
`ifdef ARGON_ALU_DIV_EN
            div_q   <= div_d;
`endif
        end
    end

    assign busy_o  = (state_q == ITER_RUN);
    assign lo_o    = nxt_lo;
    assign hi_o    = nxt_hi;
    assign state_o = state_q;

endmodule

// File: rtl/argon_alu_mdu.sv
// Argon ALU with iterative MUL/DIV on the command bus: register file, decode,
// single-cycle datapath and read mux. Define ARGON_ALU_DIV_EN to include the divider.
module argon_alu_mdu
    import alu_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic [3:0]       i_command,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_ready
);
`ifdef ARGON_ALU_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam int FW = (WIDTH < FLAG_BITS) ? WIDTH : FLAG_BITS;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d, h_q, h_d;
    logic [3:0]       op_q, op_d;
    // Only the carry of the saved flag word ever reaches the datapath.
    logic             carry_q, carry_d;
    logic             divz_q, divz_d;

    logic             iter_start, iter_busy, iter_done;
    logic [WIDTH-1:0] iter_lo, iter_hi;
    iter_state_t      iter_state;

    logic             accept, idle, is_mul, is_div;
    logic [WIDTH:0]   ea, eb, res;
    logic [WIDTH-1:0] y_live, flag_word;
    alu_flags_t       lf;

    always_comb begin
        ea  = {1'b0, a_q};
        eb  = {1'b0, b_q};
        res = '0;
        case (op_q)
            OP_ADD:  res = ea + eb;
            OP_ADC:  res = ea + eb + {{WIDTH{1'b0}}, carry_q};
            OP_SBC:  res = ea - eb - {{WIDTH{1'b0}}, carry_q};
            OP_INC:  res = ea + {{WIDTH{1'b0}}, 1'b1};
            OP_DEC:  res = ea - {{WIDTH{1'b0}}, 1'b1};
            OP_NAND: res = {1'b0, ~(a_q & b_q)};
            OP_AND:  res = {1'b0, a_q & b_q};
            OP_OR:   res = {1'b0, a_q | b_q};
            OP_NOR:  res = {1'b0, ~(a_q | b_q)};
            OP_XOR:  res = {1'b0, a_q ^ b_q};
            OP_LSH:  res = ea << b_q[SHW-1:0];
            OP_RSH:  res = ea >> b_q[SHW-1:0];
            default: res = '0;
        endcase
    end

    always_comb begin
        is_mul     = (op_q == OP_MUL);
        is_div     = DIV_ON && (op_q == OP_DIV);
        lf         = '0;
        lf.equal   = (a_q == b_q);
        lf.greater = (a_q > b_q);
        lf.less    = (a_q < b_q);
        y_live     = '0;
        if (op_q <= OP_RSH) begin
            y_live    = res[WIDTH-1:0];
            lf.carry  = res[WIDTH];
            lf.borrow = res[WIDTH] && ((op_q == OP_SBC) || (op_q == OP_DEC));
        end else if (is_mul) begin
            y_live   = y_q;
            lf.carry = |h_q;
        end else if (is_div) begin
            y_live  = y_q;
            lf.divz = divz_q;
        end
        lf.zero              = (y_live == '0);
        flag_word            = '0;
        flag_word[FW-1:0]    = lf[FW-1:0];
    end

    assign o_ready    = ~iter_busy;
    assign idle       = (iter_state == ITER_IDLE);
    assign accept     = i_valid && o_ready;
    assign iter_start = accept && (i_command == CMD_LATCH_OP) &&
                        ((i_data[3:0] == OP_MUL) || (DIV_ON && (i_data[3:0] == OP_DIV)));

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        y_d     = y_q;
        h_d     = h_q;
        divz_d  = divz_q;
        if (accept) begin
            case (i_command)
                CMD_LATCH_A:  a_d     = i_data;
                CMD_LATCH_B:  b_d     = i_data;
                CMD_LATCH_F:  carry_d = i_data[F_CARRY];
                CMD_LATCH_OP: op_d    = i_data[3:0];
                CMD_SAVE_F:   carry_d = flag_word[F_CARRY];
                default:      ;
            endcase
        end
        if (iter_start) begin
            divz_d = (i_data[3:0] == OP_DIV) && (b_q == '0);
        end
        if (iter_done) begin
            y_d = iter_lo;
            h_d = iter_hi;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            y_q     <= '0;
            h_q     <= '0;
            divz_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            y_q     <= y_d;
            h_q     <= h_d;
            divz_q  <= divz_d;
        end
    end

    // Reads are answered combinationally and suppressed while the engine runs.
    always_comb begin
        o_data  = '0;
        o_valid = 1'b0;
        if (idle) begin
            case (i_command)
                CMD_OUT_Y: begin o_data = y_live;    o_valid = 1'b1; end
                CMD_OUT_F: begin o_data = flag_word; o_valid = 1'b1; end
                CMD_OUT_H: begin o_data = h_q;       o_valid = 1'b1; end
                default:   ;
            endcase
        end
    end

    argon_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i   (i_Clk),
        .rst_ni  (i_Reset_n),
        .start_i (iter_start),
        .op_i    (i_data[3:0]),
        .a_i     (a_q),
        .b_i     (b_q),
        .busy_o  (iter_busy),
        .done_o  (iter_done),
        .lo_o    (iter_lo),
        .hi_o    (iter_hi),
        .state_o (iter_state)
    );

endmodule

// File: tb/tb_argon_alu_mdu.sv
// Directed bench for argon_alu_mdu: 16-bit vector table plus multi-cycle MUL/DIV,
// run-blocking, back-to-back and mid-run reset sequences, and a 32-bit MUL instance.
module tb_argon_alu_mdu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  cmd, cmd32;
    logic        vld, vld32;
    logic [15:0] din, dout;
    logic [31:0] din32, dout32;
    logic        dval, drdy, dval32, drdy32;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [15:0] y;
        logic [15:0] f;
    } vec_t;
    localparam int NV = 15;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    argon_alu_mdu #(.WIDTH(16)) dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_command(cmd), .i_valid(vld), .i_data(din),
        .o_data(dout), .o_valid(dval), .o_ready(drdy)
    );

    argon_alu_mdu #(.WIDTH(32)) dut32 (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_command(cmd32), .i_valid(vld32), .i_data(din32),
        .o_data(dout32), .o_valid(dval32), .o_ready(drdy32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] c, input logic [15:0] d);
        @(negedge clk);
        cmd = c; vld = 1'b1; din = d;
        @(posedge clk); #1;
        cmd = CMD_NOP; vld = 1'b0;
    endtask

    task automatic rd(input logic [3:0] c, input logic [15:0] exp, input string name);
        @(negedge clk);
        cmd = c; vld = 1'b0;
        #1;
        check(name, {16'h0, dout}, {16'h0, exp});
        check({name, "_valid"}, {31'h0, dval}, 32'h1);
        cmd = CMD_NOP;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (drdy) return;
            n++;
        end
        checks++; failures++;
        $display("FAIL busy_timeout: o_ready still low after %0d cycles", n);
    endtask

    task automatic wr32(input logic [3:0] c, input logic [31:0] d);
        @(negedge clk);
        cmd32 = c; vld32 = 1'b1; din32 = d;
        @(posedge clk); #1;
        cmd32 = CMD_NOP; vld32 = 1'b0;
    endtask

    task automatic rd32(input logic [3:0] c, input logic [31:0] exp, input string name);
        @(negedge clk);
        cmd32 = c; vld32 = 1'b0;
        #1;
        check(name, dout32, exp);
        check({name, "_valid"}, {31'h0, dval32}, 32'h1);
        cmd32 = CMD_NOP;
    endtask

    task automatic count_busy32(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (drdy32) return;
            n++;
        end
        checks++; failures++;
        $display("FAIL busy32_timeout: o_ready still low after %0d cycles", n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, busy;

        // flag word bits: carry 01, zero 02, equal 04, greater 08, less 10, borrow 20, divz 40
        vecs[0]  = '{a: 16'hFFFF, b: 16'h0001, op: OP_ADD,  y: 16'h0000, f: 16'h000B};
        vecs[1]  = '{a: 16'h1234, b: 16'h1111, op: OP_ADD,  y: 16'h2345, f: 16'h0008};
        vecs[2]  = '{a: 16'h0003, b: 16'h0003, op: OP_ADC,  y: 16'h0006, f: 16'h0004};
        vecs[3]  = '{a: 16'h0005, b: 16'h0007, op: OP_SBC,  y: 16'hFFFE, f: 16'h0031};
        vecs[4]  = '{a: 16'hFFFF, b: 16'h0000, op: OP_INC,  y: 16'h0000, f: 16'h000B};
        vecs[5]  = '{a: 16'h0000, b: 16'h0001, op: OP_DEC,  y: 16'hFFFF, f: 16'h0031};
        vecs[6]  = '{a: 16'hF0F0, b: 16'hFF00, op: OP_NAND, y: 16'h0FFF, f: 16'h0010};
        vecs[7]  = '{a: 16'hF0F0, b: 16'h0F0F, op: OP_AND,  y: 16'h0000, f: 16'h000A};
        vecs[8]  = '{a: 16'h1200, b: 16'h0034, op: OP_OR,   y: 16'h1234, f: 16'h0008};
        vecs[9]  = '{a: 16'h0000, b: 16'h0000, op: OP_NOR,  y: 16'hFFFF, f: 16'h0004};
        vecs[10] = '{a: 16'hAAAA, b: 16'h5555, op: OP_XOR,  y: 16'hFFFF, f: 16'h0008};
        vecs[11] = '{a: 16'h8001, b: 16'h0001, op: OP_LSH,  y: 16'h0002, f: 16'h0009};
        vecs[12] = '{a: 16'h8000, b: 16'h0014, op: OP_RSH,  y: 16'h0800, f: 16'h0008};
        vecs[13] = '{a: 16'h0003, b: 16'h0009, op: 4'hE,    y: 16'h0000, f: 16'h0012};
        vecs[14] = '{a: 16'h4321, b: 16'h0010, op: OP_LSH,  y: 16'h4321, f: 16'h0008};

        // clock/reset
        rst_n = 1'b0;
        cmd = CMD_NOP; vld = 1'b0; din = '0;
        cmd32 = CMD_NOP; vld32 = 1'b0; din32 = '0;
        #1;
        check("reset_ready", {31'h0, drdy}, 32'h1);
        check("reset_valid", {31'h0, dval}, 32'h0);
        check("reset_data", {16'h0, dout}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd(CMD_OUT_Y, 16'h0000, "reset_out_y");
        rd(CMD_OUT_H, 16'h0000, "reset_out_h");
        rd(CMD_OUT_F, 16'h0006, "reset_out_f");

        // single-cycle vector table
        for (int i = 0; i < NV; i++) begin
            wr(CMD_LATCH_A, vecs[i].a);
            wr(CMD_LATCH_B, vecs[i].b);
            wr(CMD_LATCH_OP, {12'h0, vecs[i].op});
            exp_q.push_back(vecs[i].y);
            exp_q.push_back(vecs[i].f);
            rd(CMD_OUT_Y, exp_q.pop_front(), $sformatf("vec%0d_y", i));
            rd(CMD_OUT_F, exp_q.pop_front(), $sformatf("vec%0d_f", i));
        end

        // saved carry feeds ADC/SBC; LATCH_F overrides it
        wr(CMD_LATCH_A, 16'hFFFF); wr(CMD_LATCH_B, 16'h0001); wr(CMD_LATCH_OP, 16'h0000);
        wr(CMD_SAVE_F, 16'h0000);
        wr(CMD_LATCH_A, 16'h0000); wr(CMD_LATCH_B, 16'h0000); wr(CMD_LATCH_OP, 16'h0001);
        rd(CMD_OUT_Y, 16'h0001, "adc_saved_carry_y");
        rd(CMD_OUT_F, 16'h0004, "adc_saved_carry_f");
        wr(CMD_LATCH_OP, 16'h0002);
        rd(CMD_OUT_Y, 16'hFFFF, "sbc_saved_carry_y");
        rd(CMD_OUT_F, 16'h0025, "sbc_saved_carry_f");
        wr(CMD_LATCH_F, 16'h0000);
        rd(CMD_OUT_Y, 16'h0000, "sbc_latch_f_y");

        // MUL with blocked read and dropped write during RUN
        wr(CMD_LATCH_A, 16'h1234); wr(CMD_LATCH_B, 16'h0100); wr(CMD_LATCH_OP, 16'h000C);
        busy = 0;
        @(negedge clk); if (!drdy) busy++;
        @(negedge clk); if (!drdy) busy++;
        cmd = CMD_OUT_Y; vld = 1'b0;
        #1;
        check("run_read_data", {16'h0, dout}, 32'h0);
        check("run_read_valid", {31'h0, dval}, 32'h0);
        cmd = CMD_NOP;
        @(negedge clk); if (!drdy) busy++;
        cmd = CMD_LATCH_A; vld = 1'b1; din = 16'h5555;
        @(posedge clk); #1;
        cmd = CMD_NOP; vld = 1'b0;
        count_busy(n);
        check("mul_busy_cycles", busy + n, 32'd16);
        rd(CMD_OUT_Y, 16'h3400, "mul_y");
        rd(CMD_OUT_H, 16'h0012, "mul_h");
        rd(CMD_OUT_F, 16'h0009, "mul_f");
        wr(CMD_LATCH_OP, 16'h0000);
        rd(CMD_OUT_Y, 16'h1334, "run_write_dropped");

        // back-to-back MUL: command held across the whole run
        wr(CMD_LATCH_A, 16'h0003); wr(CMD_LATCH_B, 16'h0005);
        @(negedge clk);
        cmd = CMD_LATCH_OP; vld = 1'b1; din = 16'h000C;
        @(posedge clk); #1;
        count_busy(n);
        check("b2b_first_busy", n, 32'd16);
        @(negedge clk);
        check("b2b_restart", {31'h0, drdy}, 32'h0);
        cmd = CMD_NOP; vld = 1'b0;
        count_busy(n);
        check("b2b_second_busy", n, 32'd15);
        rd(CMD_OUT_Y, 16'h000F, "b2b_y");
        rd(CMD_OUT_H, 16'h0000, "b2b_h");

`ifdef ARGON_ALU_DIV_EN
        wr(CMD_LATCH_A, 16'h0064); wr(CMD_LATCH_B, 16'h0007); wr(CMD_LATCH_OP, 16'h000D);
        count_busy(n);
        check("div_busy_cycles", n, 32'd16);
        rd(CMD_OUT_Y, 16'h000E, "div_y");
        rd(CMD_OUT_H, 16'h0002, "div_h");
        rd(CMD_OUT_F, 16'h0008, "div_f");
        wr(CMD_LATCH_B, 16'h0000); wr(CMD_LATCH_OP, 16'h000D);
        count_busy(n);
        check("divz_busy_cycles", n, 32'd16);
        rd(CMD_OUT_Y, 16'hFFFF, "divz_y");
        rd(CMD_OUT_H, 16'h0064, "divz_h");
        rd(CMD_OUT_F, 16'h0048, "divz_f");
`else
        wr(CMD_LATCH_A, 16'h0064); wr(CMD_LATCH_B, 16'h0007); wr(CMD_LATCH_OP, 16'h000D);
        count_busy(n);
        check("div_off_busy", n, 32'd0);
        rd(CMD_OUT_Y, 16'h0000, "div_off_y");
        rd(CMD_OUT_F, 16'h000A, "div_off_f");
        rd(CMD_OUT_H, 16'h0000, "div_off_h");
`endif

        // reset asserted in RUN cycle 7
        wr(CMD_LATCH_A, 16'h1234); wr(CMD_LATCH_B, 16'h0100); wr(CMD_LATCH_OP, 16'h000C);
        repeat (7) @(negedge clk);
        check("rst_mid_busy_before", {31'h0, drdy}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", {31'h0, drdy}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        rd(CMD_OUT_H, 16'h0000, "rst_mid_h");
        rd(CMD_OUT_Y, 16'h0000, "rst_mid_y");
        rd(CMD_OUT_F, 16'h0006, "rst_mid_f");

        // 32-bit instance
        wr32(CMD_LATCH_A, 32'hFFFF_FFFF); wr32(CMD_LATCH_B, 32'h0000_0002);
        wr32(CMD_LATCH_OP, 32'h0000_000C);
        count_busy32(n);
        check("mul32_busy_cycles", n, 32'd32);
        rd32(CMD_OUT_Y, 32'hFFFF_FFFE, "mul32_y");
        rd32(CMD_OUT_H, 32'h0000_0001, "mul32_h");
        rd32(CMD_OUT_F, 32'h0000_0009, "mul32_f");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
